// File: rtl/ptpv2_pbus_master_if.sv
// Bundle of the command, response and pbus signals around ptpv2_pbus_master.
// Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
// valid may not drop and its payload may not change until that edge.
interface ptpv2_pbus_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic [31:0] pbus_addr_o;
  logic        pbus_write_o;
  logic        pbus_sel_o;
  logic        pbus_enable_o;
  logic [31:0] pbus_wdata_o;
  logic [31:0] pbus_rdata_i;
  logic        pbus_ready_i;
  logic        pbus_slverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           pbus_rdata_i, pbus_ready_i, pbus_slverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
           pbus_addr_o, pbus_write_o, pbus_sel_o, pbus_enable_o, pbus_wdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           pbus_rdata_i, pbus_ready_i, pbus_slverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
           pbus_addr_o, pbus_write_o, pbus_sel_o, pbus_enable_o, pbus_wdata_o
  );
endinterface

// File: rtl/ptpv2_pbus_master.sv
// Single-beat command to pbus setup/access bridge with access timeout and a held response.
// All outputs are registers; state_dbg exposes the FSM state.
module ptpv2_pbus_master #(
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                pbus_clk,
  input  logic                pbus_rst,
  ptpv2_pbus_master_if.master bus,
  output logic [1:0]          state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam bit                   TO_EN   = (TIMEOUT_CYC != 0);

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  sel_q, sel_d;
  logic                  enable_q, enable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    enable_d    = enable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          write_d = bus.cmd_write_i;
          addr_d  = bus.cmd_addr_i;
          wdata_d = bus.cmd_write_i ? bus.cmd_wdata_i : 32'h0;
          if (bus.cmd_addr_i[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b0;
            rsp_rdata_d = 32'h0;
            state_d     = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        sel_d    = 1'b1;
        enable_d = 1'b0;
        state_d  = ACCESS;
      end
      ACCESS: begin
        // First ACCESS cycle shows the setup phase on the bus; ready counts only once enable is out.
        if (!enable_q) begin
          enable_d = 1'b1;
        end else if (bus.pbus_ready_i) begin
          sel_d       = 1'b0;
          enable_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'h0 : bus.pbus_rdata_i;
          rsp_err_d   = bus.pbus_slverr_i;
          rsp_to_d    = 1'b0;
          state_d     = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          sel_d       = 1'b0;
          enable_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge pbus_clk) begin
    if (pbus_rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      sel_q       <= 1'b0;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      enable_q    <= enable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready_o   = cmd_ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_to_q;
  assign bus.busy_o        = busy_q;
  assign bus.pbus_addr_o   = addr_q;
  assign bus.pbus_write_o  = write_q;
  assign bus.pbus_sel_o    = sel_q;
  assign bus.pbus_enable_o = enable_q;
  assign bus.pbus_wdata_o  = wdata_q;
  assign state_dbg         = state_q;
endmodule
